// File: rtl/line_fill_buffer.sv
// Line-fill buffer for the cache miss path: requests a line from the read channel,
// gathers its beats, forwards the missed word early and commits the full line once.
module line_fill_buffer #(
  parameter int CACHE_FRONTEND_ADDR_W = 32,
  parameter int CACHE_FRONTEND_DATA_W = 32,
  parameter int CACHE_WORD_OFF_W      = 3,
  parameter int CACHE_BACKEND_DATA_W  = 32,
  parameter int CACHE_BACKEND_BYTE_W  = $clog2(CACHE_BACKEND_DATA_W/8),
  parameter int CACHE_FRONTEND_BYTE_W = $clog2(CACHE_FRONTEND_DATA_W/8),
  parameter int CACHE_LINE2MEM_W      = CACHE_WORD_OFF_W - $clog2(CACHE_BACKEND_DATA_W/CACHE_FRONTEND_DATA_W),
  parameter int LINE_W                = (2**CACHE_WORD_OFF_W)*CACHE_FRONTEND_DATA_W,
  localparam int FILL_ADDR_W = CACHE_FRONTEND_ADDR_W - CACHE_FRONTEND_BYTE_W,
  localparam int LINE_ADDR_W = CACHE_FRONTEND_ADDR_W - (CACHE_BACKEND_BYTE_W + CACHE_LINE2MEM_W),
  localparam int BEAT_IDX_W  = (CACHE_LINE2MEM_W > 0) ? CACHE_LINE2MEM_W : 1
) (
  input  logic                             ap_clk,
  input  logic                             reset,
  input  logic                             fill_req,
  input  logic [FILL_ADDR_W-1:0]           fill_addr,
  output logic                             fill_ready,
  output logic                             replace_valid,
  output logic [LINE_ADDR_W-1:0]           replace_addr,
  input  logic                             replace,
  input  logic                             read_valid,
  input  logic [BEAT_IDX_W-1:0]            read_addr,
  input  logic [CACHE_BACKEND_DATA_W-1:0]  read_rdata,
  output logic                             word_valid,
  output logic [CACHE_FRONTEND_DATA_W-1:0] word_rdata,
  output logic                             line_we,
  output logic [LINE_ADDR_W-1:0]           line_addr,
  output logic [LINE_W-1:0]                line_wdata,
  output logic [1:0]                       dbg_state
);

  localparam int SEL_W     = CACHE_WORD_OFF_W - CACHE_LINE2MEM_W;
  localparam int SEL_BITS  = (SEL_W > 0) ? SEL_W : 1;
  localparam int WOFF_BITS = (CACHE_WORD_OFF_W > 0) ? CACHE_WORD_OFF_W : 1;
  localparam int NBEATS    = 2**CACHE_LINE2MEM_W;
  localparam int RATIO     = 2**SEL_W;
  localparam int NWORDS    = 2**CACHE_WORD_OFF_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_FILL   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t                           r_state;
  state_t                           w_next;
  logic [FILL_ADDR_W-1:0]           r_fill_addr;
  logic                             r_word_sent;
  logic [LINE_W-1:0]                r_buf;
  logic                             r_word_valid;
  logic [CACHE_FRONTEND_DATA_W-1:0] r_word_rdata;
  logic                             r_line_we;
  logic [LINE_ADDR_W-1:0]           r_line_addr;
  logic [LINE_W-1:0]                r_line_wdata;

  logic [LINE_ADDR_W-1:0]           w_line_addr;
  logic [BEAT_IDX_W-1:0]            w_beat_idx;
  logic [BEAT_IDX_W-1:0]            w_slot;
  logic [SEL_BITS-1:0]              w_word_sel;
  logic [WOFF_BITS-1:0]             w_word_idx;
  logic                             w_capture;
  logic                             w_crit_hit;
  logic                             w_commit;
  logic [CACHE_FRONTEND_DATA_W-1:0] w_crit_word;
  logic [CACHE_FRONTEND_DATA_W-1:0] w_buf_word;

  // Handshake: replace_valid is held while in REQ; the read channel answers by raising
  // replace, which stays high for the whole burst (including bus-error re-bursts) and
  // drops once the channel is done. Beats count only while read_valid and replace are both high.
  assign w_line_addr = r_fill_addr[FILL_ADDR_W-1:CACHE_WORD_OFF_W];
  assign w_beat_idx  = BEAT_IDX_W'(r_fill_addr >> SEL_W) & BEAT_IDX_W'(NBEATS - 1);
  assign w_word_sel  = SEL_BITS'(r_fill_addr) & SEL_BITS'(RATIO - 1);
  assign w_word_idx  = WOFF_BITS'(r_fill_addr) & WOFF_BITS'(NWORDS - 1);
  assign w_slot      = (CACHE_LINE2MEM_W == 0) ? '0 : read_addr;

  assign w_capture   = (r_state == S_FILL) && read_valid && replace;
  assign w_crit_hit  = w_capture && (w_slot == w_beat_idx) && !r_word_sent;
  assign w_commit    = (r_state == S_FILL) && !replace;
  assign w_crit_word = read_rdata[int'(w_word_sel)*CACHE_FRONTEND_DATA_W +: CACHE_FRONTEND_DATA_W];
  assign w_buf_word  = r_buf[int'(w_word_idx)*CACHE_FRONTEND_DATA_W +: CACHE_FRONTEND_DATA_W];

  always_ff @(posedge ap_clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (fill_req) w_next = S_REQ;
      S_REQ:    if (replace)  w_next = S_FILL;
      S_FILL:   if (!replace) w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge reset) begin
    if (reset) begin
      r_fill_addr  <= '0;
      r_word_sent  <= 1'b0;
      r_buf        <= '0;
      r_word_valid <= 1'b0;
      r_word_rdata <= '0;
      r_line_we    <= 1'b0;
      r_line_addr  <= '0;
      r_line_wdata <= '0;
    end else begin
      r_word_valid <= 1'b0;
      r_line_we    <= 1'b0;
      if ((r_state == S_IDLE) && fill_req) begin
        r_fill_addr <= fill_addr;
        r_word_sent <= 1'b0;
      end
      // Retried bursts overwrite their slots; word_sent keeps the early word to one pulse.
      if (w_capture) begin
        r_buf[int'(w_slot)*CACHE_BACKEND_DATA_W +: CACHE_BACKEND_DATA_W] <= read_rdata;
      end
      if (w_crit_hit) begin
        r_word_rdata <= w_crit_word;
        r_word_valid <= 1'b1;
        r_word_sent  <= 1'b1;
      end
      if (w_commit) begin
        r_line_we    <= 1'b1;
        r_line_addr  <= w_line_addr;
        r_line_wdata <= r_buf;
        if (!r_word_sent) begin
          r_word_rdata <= w_buf_word;
          r_word_valid <= 1'b1;
          r_word_sent  <= 1'b1;
        end
      end
    end
  end

  assign fill_ready    = (r_state == S_IDLE);
  assign replace_valid = (r_state == S_REQ);
  assign replace_addr  = w_line_addr;
  assign word_valid    = r_word_valid;
  assign word_rdata    = r_word_rdata;
  assign line_we       = r_line_we;
  assign line_addr     = r_line_addr;
  assign line_wdata    = r_line_wdata;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_line_fill_buffer.sv
// Directed bench for line_fill_buffer: table of refills on the 8x32b configuration,
// hand sequences for retry, ignored requests, reset mid-fill, back-to-back and 256b beats.
module tb_line_fill_buffer;

  localparam int FA = 30;
  localparam int RA = 27;
  localparam int LW = 256;

  logic ap_clk = 1'b0;
  logic reset;
  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  // default configuration: 8 beats of 32b
  logic          fill_req, fill_ready, replace_valid, replace, read_valid;
  logic [FA-1:0] fill_addr;
  logic [RA-1:0] replace_addr, line_addr;
  logic [2:0]    read_addr;
  logic [31:0]   read_rdata, word_rdata;
  logic          word_valid, line_we;
  logic [LW-1:0] line_wdata;
  logic [1:0]    dbg_state;

  // wide configuration: one 256b beat per line
  logic          w_fill_req, w_fill_ready, w_replace_valid, w_replace, w_read_valid;
  logic [FA-1:0] w_fill_addr;
  logic [RA-1:0] w_replace_addr, w_line_addr;
  logic [0:0]    w_read_addr;
  logic [LW-1:0] w_read_rdata, w_line_wdata;
  logic [31:0]   w_word_rdata;
  logic          w_word_valid, w_line_we;
  logic [1:0]    w_dbg_state;

  line_fill_buffer dut (
    .ap_clk(ap_clk), .reset(reset), .fill_req(fill_req), .fill_addr(fill_addr),
    .fill_ready(fill_ready), .replace_valid(replace_valid), .replace_addr(replace_addr),
    .replace(replace), .read_valid(read_valid), .read_addr(read_addr), .read_rdata(read_rdata),
    .word_valid(word_valid), .word_rdata(word_rdata), .line_we(line_we), .line_addr(line_addr),
    .line_wdata(line_wdata), .dbg_state(dbg_state)
  );

  line_fill_buffer #(.CACHE_BACKEND_DATA_W(256)) dut_w (
    .ap_clk(ap_clk), .reset(reset), .fill_req(w_fill_req), .fill_addr(w_fill_addr),
    .fill_ready(w_fill_ready), .replace_valid(w_replace_valid), .replace_addr(w_replace_addr),
    .replace(w_replace), .read_valid(w_read_valid), .read_addr(w_read_addr), .read_rdata(w_read_rdata),
    .word_valid(w_word_valid), .word_rdata(w_word_rdata), .line_we(w_line_we), .line_addr(w_line_addr),
    .line_wdata(w_line_wdata), .dbg_state(w_dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // pulse monitor on the default instance
  int            n_wv = 0, n_we = 0, wv_cyc = 0, we_cyc = 0;
  logic [31:0]   wv_data = '0;
  logic [RA-1:0] we_addr = '0;
  logic [LW-1:0] we_data = '0;
  always @(negedge ap_clk) begin
    if (word_valid) begin
      n_wv++; wv_cyc = cyc; wv_data = word_rdata;
    end
    if (line_we) begin
      n_we++; we_cyc = cyc; we_addr = line_addr; we_data = line_wdata;
    end
  end

  int beat_cyc[8];
  int last_cyc;

  task automatic tick();
    @(posedge ap_clk); #1;
  endtask

  task automatic issue(input logic [FA-1:0] a);
    fill_addr = a; fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
  endtask

  task automatic chan_accept(input logic [RA-1:0] exp_raddr);
    int n;
    n = 0;
    while (replace_valid !== 1'b1 && n < 8) begin
      tick(); n++;
    end
    check("replace_valid_latency", n, 0);
    check("replace_addr", replace_addr, exp_raddr);
    check("fill_ready_in_req", fill_ready, 1'b0);
    replace = 1'b1;
    tick();
    check("replace_valid_in_fill", replace_valid, 1'b0);
  endtask

  task automatic send_burst(input logic [31:0] base, input bit rev);
    int k;
    for (int i = 0; i < 8; i++) begin
      k = rev ? 7 - i : i;
      read_valid = 1'b1; read_addr = 3'(k); read_rdata = base + 32'(k);
      beat_cyc[k] = cyc; last_cyc = cyc;
      tick();
    end
    read_valid = 1'b0;
  endtask

  task automatic chan_finish();
    replace = 1'b0;
    tick();
    tick();
  endtask

  function automatic logic [LW-1:0] line_of(input logic [31:0] base);
    logic [LW-1:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
    return l;
  endfunction

  typedef struct {
    logic [FA-1:0] addr;
    logic [31:0]   base;
    bit            rev;
    logic [RA-1:0] exp_raddr;
    logic [31:0]   exp_word;
    int            exp_beat;
  } vec_t;
  vec_t vecs[4];

  int wv0, we0;
  logic [LW-1:0] pat;

  initial begin
    vecs[0] = '{30'h0000_0C05, 32'hA000_0000, 1'b0, 27'h000_0180, 32'hA000_0005, 5};
    vecs[1] = '{30'h0000_0000, 32'h1111_0000, 1'b0, 27'h000_0000, 32'h1111_0000, 0};
    vecs[2] = '{30'h3FFF_FFFF, 32'h2222_0000, 1'b1, 27'h7FF_FFFF, 32'h2222_0007, 7};
    vecs[3] = '{30'h0000_1233, 32'h5A5A_0000, 1'b1, 27'h000_0246, 32'h5A5A_0003, 3};

    reset = 1'b1;
    fill_req = 0; fill_addr = '0; replace = 0; read_valid = 0; read_addr = '0; read_rdata = '0;
    w_fill_req = 0; w_fill_addr = '0; w_replace = 0; w_read_valid = 0; w_read_addr = '0; w_read_rdata = '0;
    tick(); tick();
    check("rst_fill_ready", fill_ready, 1'b1);
    check("rst_replace_valid", replace_valid, 1'b0);
    check("rst_word_valid", word_valid, 1'b0);
    check("rst_line_we", line_we, 1'b0);
    check("rst_word_rdata", word_rdata, '0);
    check("rst_line_wdata", line_wdata, '0);
    check("rst_line_addr", line_addr, '0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_w_fill_ready", w_fill_ready, 1'b1);
    reset = 1'b0;
    tick();

    // table-driven refills
    for (int v = 0; v < 4; v++) begin
      wv0 = n_wv; we0 = n_we;
      issue(vecs[v].addr);
      chan_accept(vecs[v].exp_raddr);
      send_burst(vecs[v].base, vecs[v].rev);
      chan_finish();
      check("word_valid_count", 256'(n_wv - wv0), 256'(1));
      check("word_rdata", wv_data, vecs[v].exp_word);
      check("word_valid_timing", 256'(wv_cyc - beat_cyc[vecs[v].exp_beat]), 256'(1));
      check("line_we_count", 256'(n_we - we0), 256'(1));
      check("line_addr", we_addr, vecs[v].exp_raddr);
      check("line_wdata", we_data, line_of(vecs[v].base));
      check("line_we_timing", 256'(we_cyc - last_cyc), 256'(2));
      check("fill_ready_after", fill_ready, 1'b1);
      check("word_rdata_hold", word_rdata, vecs[v].exp_word);
      check("line_wdata_hold", line_wdata, line_of(vecs[v].base));
    end

    // bus error: full re-burst while replace stays high
    wv0 = n_wv; we0 = n_we;
    issue(30'h0000_2001);
    chan_accept(27'h400);
    send_burst(32'hDEAD_0000, 1'b0);
    send_burst(32'hB000_0000, 1'b0);
    chan_finish();
    check("retry_word_count", 256'(n_wv - wv0), 256'(1));
    check("retry_word", wv_data, 32'hDEAD_0001);
    check("retry_line_we_count", 256'(n_we - we0), 256'(1));
    check("retry_line", we_data, line_of(32'hB000_0000));

    // fill_req during REQ and FILL is ignored
    wv0 = n_wv; we0 = n_we;
    issue(30'h0000_0C05);
    fill_req = 1'b1; fill_addr = 30'h0ABC_DEF0;
    tick();
    check("ign_state_req", dbg_state, 2'd1);
    check("ign_fill_ready_req", fill_ready, 1'b0);
    check("ign_replace_addr_req", replace_addr, 27'h180);
    replace = 1'b1;
    tick();
    check("ign_state_fill", dbg_state, 2'd2);
    check("ign_fill_ready_fill", fill_ready, 1'b0);
    send_burst(32'hC000_0000, 1'b0);
    check("ign_replace_addr_fill", replace_addr, 27'h180);
    fill_req = 1'b0;
    chan_finish();
    check("ign_word", wv_data, 32'hC000_0005);
    check("ign_line_addr", we_addr, 27'h180);
    check("ign_line_we_count", 256'(n_we - we0), 256'(1));

    // reset asserted while beat 3 is on the bus
    wv0 = n_wv; we0 = n_we;
    issue(30'h0000_0C05);
    chan_accept(27'h180);
    for (int k = 0; k < 3; k++) begin
      read_valid = 1'b1; read_addr = 3'(k); read_rdata = 32'hE000_0000 + 32'(k);
      tick();
    end
    read_addr = 3'd3; read_rdata = 32'hE000_0003;
    reset = 1'b1;
    #1;
    check("midrst_state", dbg_state, 2'd0);
    check("midrst_fill_ready", fill_ready, 1'b1);
    check("midrst_replace_valid", replace_valid, 1'b0);
    read_valid = 1'b0; replace = 1'b0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("midrst_no_line_we", 256'(n_we - we0), 256'(0));
    check("midrst_no_word", 256'(n_wv - wv0), 256'(0));
    check("midrst_line_wdata", line_wdata, '0);

    // back-to-back: fill_req held across two fills
    we0 = n_we;
    fill_addr = 30'h0000_0C05; fill_req = 1'b1;
    tick();
    chan_accept(27'h180);
    fill_addr = 30'h0000_1233;
    send_burst(32'hA000_0000, 1'b0);
    replace = 1'b0;
    tick();
    check("b2b_commit_state", dbg_state, 2'd3);
    check("b2b_commit_we", line_we, 1'b1);
    check("b2b_commit_replace_valid", replace_valid, 1'b0);
    tick();
    check("b2b_idle_state", dbg_state, 2'd0);
    check("b2b_idle_ready", fill_ready, 1'b1);
    tick();
    check("b2b_req2_valid", replace_valid, 1'b1);
    check("b2b_req2_addr", replace_addr, 27'h246);
    fill_req = 1'b0;
    chan_accept(27'h246);
    send_burst(32'h5A5A_0000, 1'b0);
    chan_finish();
    check("b2b_word2", wv_data, 32'h5A5A_0003);
    check("b2b_line2", we_data, line_of(32'h5A5A_0000));
    check("b2b_line_we_count", 256'(n_we - we0), 256'(2));

    // wide beat: whole line in one beat, read_addr ignored
    for (int j = 0; j < 8; j++) pat[j*32 +: 32] = 32'h1111_1111 * 32'(j);
    w_fill_addr = 30'h0000_00F6; w_fill_req = 1'b1;
    tick();
    w_fill_req = 1'b0;
    check("w_replace_valid", w_replace_valid, 1'b1);
    check("w_replace_addr", w_replace_addr, 27'h1E);
    w_replace = 1'b1;
    tick();
    w_read_valid = 1'b1; w_read_addr = 1'b1; w_read_rdata = pat;
    tick();
    w_read_valid = 1'b0; w_replace = 1'b0;
    check("w_word_valid", w_word_valid, 1'b1);
    check("w_word_rdata", w_word_rdata, 32'h6666_6666);
    check("w_line_we_early", w_line_we, 1'b0);
    tick();
    check("w_line_we", w_line_we, 1'b1);
    check("w_line_wdata", w_line_wdata, pat);
    check("w_line_addr", w_line_addr, 27'h1E);
    check("w_word_valid_once", w_word_valid, 1'b0);
    tick();
    check("w_line_we_once", w_line_we, 1'b0);
    check("w_fill_ready", w_fill_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
